// File: rtl/chan_mux_scan_if.sv
// chan_mux_scan_if: bundles the channel inputs, mode controls and the
// registered valid/ready output of chan_mux_scan.
//   master : drives din/sel/mode/en/dwell/y_ready, observes y/y_ch/y_valid/wrap
//   slave  : the selector itself
interface chan_mux_scan_if #(
  parameter int NCH     = 4,
  parameter int W       = 8,
  parameter int DWELL_W = 8
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH*W-1:0]   din;
  logic [SW-1:0]      sel;
  logic               mode;
  logic               en;
  logic [DWELL_W-1:0] dwell;
  logic [W-1:0]       y;
  logic [SW-1:0]      y_ch;
  logic               y_valid;
  logic               y_ready;
  logic               wrap;

  modport master (
    output din, sel, mode, en, dwell, y_ready,
    input  y, y_ch, y_valid, wrap
  );

  modport slave (
    input  din, sel, mode, en, dwell, y_ready,
    output y, y_ch, y_valid, wrap
  );
endinterface

// File: rtl/chan_mux_scan.sv
// chan_mux_scan: NCH-channel, W-bit registered selector with a DIRECT mode
// (external sel) and a SCAN mode (round-robin, dwell samples per channel).
// Output is a one-entry register with valid/ready handshake; a new sample is
// captured whenever en is high and the register is empty or being drained.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : chan_mux_scan_if.slave (din, sel, mode, en, dwell, y_ready in;
//                y, y_ch, y_valid, wrap out)
module chan_mux_scan #(
  parameter int NCH     = 4,
  parameter int W       = 8,
  parameter int DWELL_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  chan_mux_scan_if.slave bus
);
  localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0] LAST_CH = SW'(NCH - 1);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         y_q, y_d;
  logic [SW-1:0]        y_ch_q, y_ch_d;
  logic                 y_valid_q, y_valid_d;
  logic                 wrap_q, wrap_d;
  logic [SW-1:0]        ptr_q, ptr_d;
  logic [DWELL_W-1:0]   dcnt_q, dcnt_d;

  logic [NCH-1:0][W-1:0] ch;
  logic                  cap, entering, last;
  logic [SW-1:0]         ptr_eff, sel_eff;
  logic [DWELL_W-1:0]    dcnt_eff;
  logic [DWELL_W:0]      dcnt_inc, dwell_eff;

  assign ch = bus.din;

  always_comb begin
    state_d   = !bus.en ? IDLE : (bus.mode ? SCAN : DIRECT);
    // Entering SCAN restarts the scan at channel 0 regardless of stale state.
    entering  = (state_d == SCAN) && (state_q != SCAN);
    ptr_eff   = entering ? '0 : ptr_q;
    dcnt_eff  = entering ? '0 : dcnt_q;
    sel_eff   = (int'(bus.sel) >= NCH) ? LAST_CH : bus.sel;
    cap       = bus.en && (!y_valid_q || bus.y_ready);
    // One extra bit so dcnt+1 never overflows; dwell 0 behaves as 1.
    dcnt_inc  = {1'b0, dcnt_eff} + 1'b1;
    dwell_eff = (bus.dwell == '0) ? (DWELL_W+1)'(1) : {1'b0, bus.dwell};
    last      = (dcnt_inc >= dwell_eff);

    y_d       = y_q;
    y_ch_d    = y_ch_q;
    y_valid_d = y_valid_q && !bus.y_ready;
    wrap_d    = 1'b0;
    ptr_d     = ptr_eff;
    dcnt_d    = dcnt_eff;

    if (cap) begin
      y_valid_d = 1'b1;
      if (state_d == SCAN) begin
        y_d    = ch[ptr_eff];
        y_ch_d = ptr_eff;
        if (last) begin
          dcnt_d = '0;
          ptr_d  = (ptr_eff == LAST_CH) ? '0 : SW'(ptr_eff + 1'b1);
          wrap_d = (ptr_eff == LAST_CH);
        end else begin
          dcnt_d = dcnt_inc[DWELL_W-1:0];
        end
      end else begin
        y_d    = ch[sel_eff];
        y_ch_d = sel_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      ptr_q     <= '0;
      dcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      y_ch_q    <= y_ch_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      ptr_q     <= ptr_d;
      dcnt_q    <= dcnt_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;
  assign bus.wrap    = wrap_q;
endmodule

// File: tb/tb_chan_mux_scan.sv
// Testbench for chan_mux_scan: table of directed vectors plus hand-written
// sequences for backpressure, stale-pointer mode switch and reset mid-stream.
module tb_chan_mux_scan;
  logic clk;
  logic rst_n;

  chan_mux_scan_if #(.NCH(4), .W(8), .DWELL_W(8)) bus ();

  chan_mux_scan #(.NCH(4), .W(8), .DWELL_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       en;
    logic       mode;
    logic [1:0] sel;
    logic [7:0] dwell;
    logic       rdy;
    logic [7:0] y;
    logic [1:0] ch;
    logic       v;
    logic       w;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic add(input logic en, input logic mode, input logic [1:0] sel,
                     input logic [7:0] dwell, input logic rdy, input logic [7:0] y,
                     input logic [1:0] ch, input logic v, input logic w);
    vec_t r;
    r.en = en; r.mode = mode; r.sel = sel; r.dwell = dwell; r.rdy = rdy;
    r.y = y; r.ch = ch; r.v = v; r.w = w;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_out(input string tag, input logic [7:0] y, input logic [1:0] ch,
                         input logic v, input logic w);
    chk({tag, ".y"},       32'(bus.y),       32'(y));
    chk({tag, ".y_ch"},    32'(bus.y_ch),    32'(ch));
    chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'(v));
    chk({tag, ".wrap"},    32'(bus.wrap),    32'(w));
  endtask

  task automatic drive(input logic en, input logic mode, input logic [1:0] sel,
                       input logic [7:0] dwell, input logic rdy);
    bus.en = en; bus.mode = mode; bus.sel = sel; bus.dwell = dwell; bus.y_ready = rdy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.din = {8'h44, 8'h33, 8'h22, 8'h11};
    drive(1'b0, 1'b0, 2'd0, 8'd0, 1'b1);
    #1;
    chk_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    #11;
    rst_n = 1'b1;

    // DIRECT sel 0..3, continuous valid
    add(1, 0, 2'd0, 8'd0, 1, 8'h11, 2'd0, 1, 0);
    add(1, 0, 2'd1, 8'd0, 1, 8'h22, 2'd1, 1, 0);
    add(1, 0, 2'd2, 8'd0, 1, 8'h33, 2'd2, 1, 0);
    add(1, 0, 2'd3, 8'd0, 1, 8'h44, 2'd3, 1, 0);
    // SCAN dwell=2: 0,0,1,1,2,2,3,3,0; wrap with the last ch3 sample
    add(1, 1, 2'd0, 8'd2, 1, 8'h11, 2'd0, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h11, 2'd0, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h22, 2'd1, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h22, 2'd1, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h33, 2'd2, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h33, 2'd2, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h44, 2'd3, 1, 0);
    add(1, 1, 2'd0, 8'd2, 1, 8'h44, 2'd3, 1, 1);
    add(1, 1, 2'd0, 8'd2, 1, 8'h11, 2'd0, 1, 0);
    // idle with accept: valid drops, data held
    add(0, 0, 2'd0, 8'd0, 1, 8'h11, 2'd0, 0, 0);
    // SCAN dwell=0 behaves as 1
    add(1, 1, 2'd0, 8'd0, 1, 8'h11, 2'd0, 1, 0);
    add(1, 1, 2'd0, 8'd0, 1, 8'h22, 2'd1, 1, 0);
    add(1, 1, 2'd0, 8'd0, 1, 8'h33, 2'd2, 1, 0);
    add(1, 1, 2'd0, 8'd0, 1, 8'h44, 2'd3, 1, 1);
    add(1, 1, 2'd0, 8'd0, 1, 8'h11, 2'd0, 1, 0);
    // DIRECT one sample then en=0: valid drops, y holds
    add(1, 0, 2'd2, 8'd0, 1, 8'h33, 2'd2, 1, 0);
    add(0, 0, 2'd2, 8'd0, 1, 8'h33, 2'd2, 0, 0);
    add(0, 0, 2'd2, 8'd0, 1, 8'h33, 2'd2, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].mode, vecs[i].sel, vecs[i].dwell, vecs[i].rdy);
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].ch, vecs[i].v, vecs[i].w);
    end

    // Backpressure in SCAN: first sample held for 5 stalled cycles
    drive(1'b1, 1'b1, 2'd0, 8'd1, 1'b0);
    step();
    chk_out("bp_first", 8'h11, 2'd0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk_out($sformatf("bp_hold%0d", k), 8'h11, 2'd0, 1'b1, 1'b0);
    end
    bus.y_ready = 1'b1;
    step();
    chk_out("bp_rel1", 8'h22, 2'd1, 1'b1, 1'b0);
    step();
    chk_out("bp_rel2", 8'h33, 2'd2, 1'b1, 1'b0);

    // Stale pointer (at 3): DIRECT detour, then SCAN restarts at ch0 with dcnt=0
    drive(1'b1, 1'b0, 2'd1, 8'd2, 1'b1);
    step();
    chk_out("sw_direct", 8'h22, 2'd1, 1'b1, 1'b0);
    bus.mode = 1'b1;
    step();
    chk_out("sw_scan0", 8'h11, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("sw_scan1", 8'h11, 2'd0, 1'b1, 1'b0);
    step();
    chk_out("sw_scan2", 8'h22, 2'd1, 1'b1, 1'b0);

    // Reset mid-stream clears outputs without a clock edge
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 8'h00, 2'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
